// File: rtl/arith_pkg.sv
// Shared arithmetic primitives: lane width default and 1-bit half-adder functions.
// Latency: none (pure functions and constants).
// Backpressure: not applicable.
package arith_pkg;

    // Scalar half adder unless the instantiating context widens it
    localparam int HA_DEFAULT_WIDTH = 1;

    // Sum bit of a half adder: set when exactly one input is set
    function automatic logic ha_sum(input logic i_a, input logic i_b);
        return i_a ^ i_b;
    endfunction

    // Carry bit of a half adder: set only when both inputs are set
    function automatic logic ha_carry(input logic i_a, input logic i_b);
        return i_a & i_b;
    endfunction

endpackage

// File: rtl/half_adder_bit.sv
// One half-adder lane: (a,b) -> (sum,carry), no state.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows input continuously.
module half_adder_bit
    import arith_pkg::*;
(
    input  logic i_a,
    input  logic i_b,
    output logic o_sum,
    output logic o_carry
);

    // Lane results straight from the shared primitive functions
    assign o_sum   = ha_sum(i_a, i_b);
    assign o_carry = ha_carry(i_a, i_b);

endmodule

// File: rtl/half_adder_pipe.sv
// WIDTH independent half-adder lanes with capture-on-valid result registers.
// Latency: 1 cycle when REG_OUT=1; sum/carry combinational when REG_OUT=0 (out_valid always registered).
// Backpressure: none; accepts a new input every cycle and holds the last result while in_valid is low.
module half_adder_pipe
    import arith_pkg::*;
#(
    parameter int WIDTH   = HA_DEFAULT_WIDTH,
    parameter bit REG_OUT = 1'b1
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic             carry_any,
    output logic             out_valid
);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_carry;
    logic             w_carry_any;
    logic             r_out_valid;

    // Lanes never interact: no carry is chained from lane i to lane i+1
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
        half_adder_bit u_lane (
            .i_a     (a[gi]),
            .i_b     (b[gi]),
            .o_sum   (w_sum[gi]),
            .o_carry (w_carry[gi])
        );
    end

    assign w_carry_any = |w_carry;

    // Sticky valid: set by the first capture, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
        end else if (in_valid) begin
            r_out_valid <= 1'b1;
        end
    end

    assign out_valid = r_out_valid;

    if (REG_OUT) begin : g_reg_out
        logic [WIDTH-1:0] r_sum;
        logic [WIDTH-1:0] r_carry;
        logic             r_carry_any;

        // Capture only on in_valid so idle-cycle garbage (including X) never reaches the registers
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sum       <= '0;
                r_carry     <= '0;
                r_carry_any <= 1'b0;
            end else if (in_valid) begin
                r_sum       <= w_sum;
                r_carry     <= w_carry;
                r_carry_any <= w_carry_any;
            end
        end

        assign sum       = r_sum;
        assign carry     = r_carry;
        assign carry_any = r_carry_any;
    end else begin : g_comb_out
        // Unregistered variant: results track a/b regardless of in_valid or reset
        assign sum       = w_sum;
        assign carry     = w_carry;
        assign carry_any = w_carry_any;
    end

endmodule

// File: tb/tb_half_adder_pipe.sv
`timescale 1ns/1ps
module tb_half_adder_pipe;

    typedef struct packed {
        logic [7:0] s;
        logic [7:0] c;
    } res_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a8;
    logic [7:0] b8;

    // WIDTH=8 registered instance
    logic [7:0] sum8, carry8;
    logic       cany8, ovld8;
    // WIDTH=1 registered instance (lane 0 of the stimulus)
    logic       sum1, carry1, cany1, ovld1;
    // WIDTH=1 combinational instance (lane 0 of the stimulus)
    logic       sum0, carry0, cany0, ovld0;

    half_adder_pipe #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8), .b(b8),
        .sum(sum8), .carry(carry8), .carry_any(cany8), .out_valid(ovld8)
    );

    half_adder_pipe #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8[0]), .b(b8[0]),
        .sum(sum1), .carry(carry1), .carry_any(cany1), .out_valid(ovld1)
    );

    half_adder_pipe #(.WIDTH(1), .REG_OUT(1'b0)) u_c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8[0]), .b(b8[0]),
        .sum(sum0), .carry(carry0), .carry_any(cany0), .out_valid(ovld0)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    int   n_tests = 0;
    int   n_fail  = 0;
    res_t q[$];
    res_t held;
    logic held_vld;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic ea, eb;
        ea = a8[0];
        eb = b8[0];
        chk({tag, ".w8_sum"},   {24'd0, sum8},   {24'd0, held.s});
        chk({tag, ".w8_carry"}, {24'd0, carry8}, {24'd0, held.c});
        chk({tag, ".w8_cany"},  {31'd0, cany8},  {31'd0, |held.c});
        chk({tag, ".w8_vld"},   {31'd0, ovld8},  {31'd0, held_vld});
        chk({tag, ".w1_sum"},   {31'd0, sum1},   {31'd0, held.s[0]});
        chk({tag, ".w1_carry"}, {31'd0, carry1}, {31'd0, held.c[0]});
        chk({tag, ".w1_cany"},  {31'd0, cany1},  {31'd0, held.c[0]});
        chk({tag, ".w1_vld"},   {31'd0, ovld1},  {31'd0, held_vld});
        chk({tag, ".c1_sum"},   {31'd0, sum0},   {31'd0, ea ^ eb});
        chk({tag, ".c1_carry"}, {31'd0, carry0}, {31'd0, ea & eb});
        chk({tag, ".c1_cany"},  {31'd0, cany0},  {31'd0, ea & eb});
        chk({tag, ".c1_vld"},   {31'd0, ovld0},  {31'd0, held_vld});
    endtask

    // Drive one input, push its expected result, let one edge pass, check at the falling edge
    task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b, input string tag);
        res_t r;
        in_valid = v;
        a8 = a;
        b8 = b;
        if (v) begin
            r.s = a ^ b;
            r.c = a & b;
            q.push_back(r);
        end
        @(posedge clk);
        if (v) begin
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $error("FAIL %s.queue observed=empty expected=entry", tag);
            end else begin
                held     = q.pop_front();
                held_vld = 1'b1;
            end
        end
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        rst_n    = 1'b1;
        in_valid = 1'b0;
        a8       = 8'h00;
        b8       = 8'h00;
        held     = '0;
        held_vld = 1'b0;

        // Asynchronous reset with active-looking inputs, checked before any clock edge
        #5;
        in_valid = 1'b1;
        a8       = 8'hFF;
        b8       = 8'hFF;
        rst_n    = 1'b0;
        #5;
        check_all("reset_async");
        @(posedge clk);
        @(negedge clk);
        check_all("reset_hold");
        rst_n    = 1'b1;
        in_valid = 1'b0;
        a8       = 8'h00;
        b8       = 8'h00;
        @(posedge clk);
        @(negedge clk);
        check_all("post_reset_idle");

        // Exhaustive scalar truth table, one input per cycle
        step(1'b1, 8'h00, 8'h00, "tt_00");
        step(1'b1, 8'h01, 8'h00, "tt_10");
        step(1'b1, 8'h00, 8'h01, "tt_01");
        step(1'b1, 8'h01, 8'h01, "tt_11");

        // Hold: capture (1,0) then idle with (1,1) present on the inputs
        step(1'b1, 8'h01, 8'h00, "hold_cap");
        for (int i = 0; i < 5; i++) step(1'b0, 8'h01, 8'h01, "hold_idle");
        step(1'b0, 8'hxx, 8'hxx, "hold_x");

        // Multi-lane patterns
        step(1'b1, 8'hF0, 8'hAA, "w8_f0_aa");
        step(1'b1, 8'h0F, 8'h30, "w8_0f_30");
        step(1'b1, 8'hFF, 8'h01, "w8_ff_01");

        // Combinational instance follows inputs with no clock edge
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            ab = i[1:0];
            a8 = {7'd0, ab[1]};
            b8 = {7'd0, ab[0]};
            #1;
            check_all("comb_toggle");
        end

        // Back-to-back stream interrupted by a mid-cycle reset
        step(1'b1, 8'h12, 8'h34, "b2b_1");
        step(1'b1, 8'hC3, 8'h5A, "b2b_2");
        in_valid = 1'b1;
        a8       = 8'h77;
        b8       = 8'h7E;
        #10;
        rst_n    = 1'b0;
        q.delete();
        held     = '0;
        held_vld = 1'b0;
        #1;
        check_all("midreset_clear");
        @(posedge clk);
        @(negedge clk);
        check_all("midreset_hold");
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all("midreset_release");
        step(1'b1, 8'hAA, 8'hFF, "after_reset_cap");
        step(1'b1, 8'h01, 8'h01, "after_reset_cap2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/half_adder_pipe.md
Name: half_adder_pipe

Overview:
- Registered, WIDTH-lane half adder.
- Each lane computes the 1-bit sum (a XOR b) and carry (a AND b) of its two input bits, independently of the other lanes.
- Results are captured on a valid strobe and held until the next valid input.
- Used as a leaf arithmetic primitive feeding adder trees and parity/carry logic. WIDTH=1 is the scalar half adder.

Parameters:
- WIDTH, 1, number of independent half-adder lanes (>=1).
- REG_OUT, 1, 1 = outputs registered (latency 1 cycle); 0 = sum/carry combinational, out_valid still registered.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  a/b are valid this cycle; capture them
- a  input  WIDTH  addend lane bits
- b  input  WIDTH  addend lane bits
- sum  output  WIDTH  per-lane a[i] XOR b[i]
- carry  output  WIDTH  per-lane a[i] AND b[i]
- carry_any  output  1  OR-reduction of carry
- out_valid  output  1  sum/carry/carry_any reflect a captured input

Behaviour:
- Lane function: sum[i] = a[i] ^ b[i]; carry[i] = a[i] & b[i]. Lanes never interact; carry is not propagated between lanes.
- Truth table per lane (a,b -> sum,carry):
  - 0,0 -> 0,0
  - 1,0 -> 1,0
  - 0,1 -> 1,0
  - 1,1 -> 0,1
- Reset (rst_n low, asynchronous, no clock needed):
  - sum=0, carry=0, carry_any=0, out_valid=0.
  - All values hold while rst_n is low.
  - The first capture is on the first rising clk with rst_n high.
- REG_OUT=1:
  - On a rising clk with in_valid=1: register sum/carry/carry_any from the current a/b and set out_valid=1 (latency 1 cycle).
  - in_valid=0: hold the previous result registers. out_valid stays 1 once any result has been captured, and only reset clears it.
  - Back-to-back in_valid: a new result every cycle, no bubbles, no backpressure.
- REG_OUT=0:
  - sum/carry/carry_any follow a/b combinationally at all times, independent of in_valid and reset.
  - out_valid behaves exactly as in REG_OUT=1.
- Reset asserted mid-stream clears the outputs immediately. The in-flight capture is lost and no partial result is presented.
- X on a/b while in_valid=0 must not propagate into the registers.
- No overflow condition exists: a per-lane result of at most 2 fits exactly in carry:sum.

Decomposition:
- Shared package (arith_pkg):
  - default WIDTH constant
  - function ha_sum(a,b)
  - function ha_carry(a,b)
- Sub-module half_adder_bit: purely combinational 1-bit lane (a,b -> sum,carry), instantiated WIDTH times by a generate loop.
- The top level owns the capture registers, the carry_any reduction and out_valid.

Test Plan:
- Reset: drive rst_n=0 with a=1,b=1,in_valid=1 -> sum=0, carry=0, out_valid=0 asynchronously, with no clock edge needed.
- Exhaustive WIDTH=1 sequence, one input per 100 ns, REG_OUT=1 -> each result appears one edge after its input:
  - (0,0) -> sum=0, carry=0
  - (1,0) -> sum=1, carry=0
  - (0,1) -> sum=1, carry=0
  - (1,1) -> sum=0, carry=1
- Hold: capture (1,0), then in_valid=0 with a=1,b=1 for 5 cycles -> sum=1, carry=0, out_valid=1 unchanged.
- WIDTH=8 lanes, a=0xF0, b=0xAA, in_valid=1 -> next cycle sum=0x5A, carry=0xA0, carry_any=1. Then a=0x0F, b=0x30 -> sum=0x3F, carry=0x00, carry_any=0.
- Back-to-back then reset: stream 4 valid inputs on consecutive cycles, assert rst_n=0 mid-cycle after the 2nd -> outputs clear immediately. After release, out_valid=0 until the next in_valid capture.
- REG_OUT=0, WIDTH=1: toggle a/b without a clock -> sum/carry follow the truth table within the same delta; out_valid rises only on a clocked in_valid.
